// File: rtl/vga_sram_ctrl.sv
// vga_sram_ctrl: Avalon-MM slave driving a 16-bit async SRAM, one command in flight.
// Define SRAM_IO_REG_EN to sample sram_dq through an input flop (adds one read cycle).
module vga_sram_ctrl #(
  parameter int AVN_AW    = 18,
  parameter int AVN_DW    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  avn_read,
  input  logic                  avn_write,
  input  logic [AVN_AW-1:0]     avn_address,
  input  logic [AVN_DW-1:0]     avn_writedata,
  input  logic [AVN_DW/8-1:0]   avn_byteenable,
  output logic [AVN_DW-1:0]     avn_readdata,
  output logic                  avn_readdatavalid,
  output logic                  avn_waitrequest,
  output logic [AVN_AW-1:0]     sram_addr,
  inout  wire  [AVN_DW-1:0]     sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
`ifdef SRAM_IO_REG_EN
  localparam int RD_LOAD = RD_CYCLES;
`else
  localparam int RD_LOAD = RD_CYCLES - 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    WR_HOLD
  } state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [AVN_AW-1:0]   addr_d;
  logic [AVN_DW-1:0]   wdata, wdata_d;
  logic                dq_oe, dq_oe_d;
  logic                ce_d, oe_d, we_d, ub_d, lb_d;
  logic [AVN_DW-1:0]   rdata_d;
  logic                rdv_d;
  logic [AVN_DW-1:0]   cap;

  assign sram_dq = dq_oe ? wdata : {AVN_DW{1'bz}};

  assign avn_waitrequest = (state != IDLE) | ~sys_rst_n;

`ifdef SRAM_IO_REG_EN
  logic [AVN_DW-1:0] dq_q;

  // input flop on the data pins, sampled every cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dq_q <= '0;
    else            dq_q <= sram_dq;
  end

  assign cap = dq_q;
`else
  assign cap = sram_dq;
`endif

  // next state plus next value of every registered pin
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = sram_addr;
    wdata_d = wdata;
    dq_oe_d = 1'b0;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    ub_d    = 1'b1;
    lb_d    = 1'b1;
    rdata_d = avn_readdata;
    rdv_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (avn_write) begin
          state_d = WR;
          addr_d  = avn_address;
          wdata_d = avn_writedata;
          ub_d    = ~avn_byteenable[1];
          lb_d    = ~avn_byteenable[0];
          cnt_d   = CW'(WR_CYCLES - 1);
          ce_d    = 1'b0;
          we_d    = 1'b0;
          dq_oe_d = 1'b1;
        end else if (avn_read) begin
          state_d = RD;
          addr_d  = avn_address;
          ub_d    = 1'b0;
          lb_d    = 1'b0;
          cnt_d   = CW'(RD_LOAD);
          ce_d    = 1'b0;
          oe_d    = 1'b0;
        end
      end
      RD: begin
        if (cnt == '0) begin
          state_d = IDLE;
          rdata_d = cap;
          rdv_d   = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
          ce_d  = 1'b0;
          oe_d  = 1'b0;
          ub_d  = sram_ub_n;
          lb_d  = sram_lb_n;
        end
      end
      WR: begin
        ce_d    = 1'b0;
        dq_oe_d = 1'b1;
        ub_d    = sram_ub_n;
        lb_d    = sram_lb_n;
        if (cnt == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt - 1'b1;
          we_d  = 1'b0;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and all SRAM/Avalon output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      sram_addr         <= '0;
      wdata             <= '0;
      dq_oe             <= 1'b0;
      sram_ce_n         <= 1'b1;
      sram_oe_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      sram_ub_n         <= 1'b1;
      sram_lb_n         <= 1'b1;
      avn_readdata      <= '0;
      avn_readdatavalid <= 1'b0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      sram_addr         <= addr_d;
      wdata             <= wdata_d;
      dq_oe             <= dq_oe_d;
      sram_ce_n         <= ce_d;
      sram_oe_n         <= oe_d;
      sram_we_n         <= we_d;
      sram_ub_n         <= ub_d;
      sram_lb_n         <= lb_d;
      avn_readdata      <= rdata_d;
      avn_readdatavalid <= rdv_d;
    end
  end

endmodule

// File: tb/tb_vga_sram_ctrl.sv
// tb_vga_sram_ctrl: directed + random checks of vga_sram_ctrl
// against an SRAM device model and a word-level expected-content map.
module tb_vga_sram_ctrl;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int RDC = 2;
  localparam int WRC = 2;
`ifdef SRAM_IO_REG_EN
  localparam int RD_LAT = RDC + 2;
`else
  localparam int RD_LAT = RDC + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          avn_read, avn_write;
  logic [AW-1:0] avn_address;
  logic [DW-1:0] avn_writedata;
  logic [1:0]    avn_byteenable;
  logic [DW-1:0] avn_readdata;
  logic          rdv, wait_r;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          ce_n, oe_n, we_n, ub_n, lb_n;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] wr_map [int];
  logic          probe_en;
  logic [DW-1:0] probe_val;
  logic          mdrv;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_sram_ctrl #(
    .AVN_AW(AW), .AVN_DW(DW),
    .RD_CYCLES(RDC), .WR_CYCLES(WRC)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .avn_read(avn_read),
    .avn_write(avn_write),
    .avn_address(avn_address),
    .avn_writedata(avn_writedata),
    .avn_byteenable(avn_byteenable),
    .avn_readdata(avn_readdata),
    .avn_readdatavalid(rdv),
    .avn_waitrequest(wait_r),
    .sram_addr(sram_addr),
    .sram_dq(sram_dq),
    .sram_ce_n(ce_n),
    .sram_oe_n(oe_n),
    .sram_we_n(we_n),
    .sram_ub_n(ub_n),
    .sram_lb_n(lb_n)
  );

  // async SRAM device: drives data on read, stores byte lanes while WE_n low
  assign mdrv = !ce_n && !oe_n && we_n;
  assign sram_dq = mdrv ? mem[sram_addr] :
                   (probe_en ? probe_val : {DW{1'bz}});

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
    end
  end

  function automatic logic [15:0] init_fn(input int a);
    logic [31:0] x;
    x = (a * 32'd40503) ^ (a >> 5) ^ 32'h3C5A;
    return x[15:0];
  endfunction

  function automatic logic [15:0] exp_rd(input int a);
    if (wr_map.exists(a)) return wr_map[a];
    return init_fn(a);
  endfunction

  task automatic model_write(input int a, input logic [15:0] d,
                             input logic [1:0] be);
    logic [15:0] w;
    w = exp_rd(a);
    if (be[1]) w[15:8] = d[15:8];
    if (be[0]) w[7:0]  = d[7:0];
    wr_map[a] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input int a, input logic [15:0] d,
                          input logic [1:0] be);
    int n;
    avn_write = 1'b1;
    avn_address = AW'(a);
    avn_writedata = d;
    avn_byteenable = be;
    step;
    avn_write = 1'b0;
    avn_address = AW'($urandom);
    avn_writedata = 16'($urandom);
    n = 1;
    while (wait_r && n < 20) begin
      step;
      n++;
    end
    chk("wr_busy", n, WRC + 2);
    model_write(a, d, be);
  endtask

  task automatic do_read(input int a, output logic [15:0] d,
                         output int lat);
    avn_read = 1'b1;
    avn_address = AW'(a);
    step;
    avn_read = 1'b0;
    avn_address = AW'($urandom);
    lat = 1;
    while (!rdv && lat < 20) begin
      step;
      lat++;
    end
    d = avn_readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int lat, seen, issued, got, a;
    int q_addr[$];
    int q_t[$];

    for (int i = 0; i < (1 << AW); i++) mem[i] = init_fn(i);
    rst_n = 1'b0;
    avn_read = 1'b0;
    avn_write = 1'b0;
    avn_address = '0;
    avn_writedata = '0;
    avn_byteenable = 2'b11;
    probe_en = 1'b1;
    probe_val = 16'h5A5A;
    step;
    step;

    // reset state
    chk("rst_wait", wait_r, 1);
    chk("rst_pins", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", avn_readdata, 0);
    chk("rst_rdv", rdv, 0);
    chk("rst_dq_hiz", sram_dq, 16'h5A5A);
    rst_n = 1'b1;
    probe_en = 1'b0;
    step;
    chk("idle_wait", wait_r, 0);

    // full write with pin-level checks, inputs scrambled while busy
    avn_write = 1'b1;
    avn_address = 18'h00010;
    avn_writedata = 16'hA55A;
    avn_byteenable = 2'b11;
    step;
    avn_write = 1'b0;
    avn_address = 18'h3FFFF;
    avn_writedata = 16'hFFFF;
    chk("w1_pins", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b01000);
    chk("w1_dq", sram_dq, 16'hA55A);
    chk("w1_addr", sram_addr, 18'h00010);
    chk("w1_wait", wait_r, 1);
    step;
    chk("w2_we", we_n, 0);
    chk("w2_dq", sram_dq, 16'hA55A);
    step;
    chk("whold_pins", {ce_n, oe_n, we_n}, 3'b011);
    chk("whold_dq", sram_dq, 16'hA55A);
    chk("whold_wait", wait_r, 1);
    step;
    chk("wdone_wait", wait_r, 0);
    chk("wdone_ce", ce_n, 1);
    chk("wdone_mem", mem[18'h10], 16'hA55A);
    model_write(18'h10, 16'hA55A, 2'b11);

    // readback
    do_read(18'h10, d, lat);
    chk("rd1_lat", lat, RD_LAT);
    chk("rd1_data", d, exp_rd(18'h10));
    step;
    chk("rd1_pulse", rdv, 0);
    chk("rd1_hold", avn_readdata, 16'hA55A);

    // lower-byte write
    avn_write = 1'b1;
    avn_address = 18'h00010;
    avn_writedata = 16'h1234;
    avn_byteenable = 2'b01;
    step;
    avn_write = 1'b0;
    chk("bw_lanes", {ub_n, lb_n}, 2'b10);
    step;
    step;
    step;
    chk("bw_wait", wait_r, 0);
    model_write(18'h10, 16'h1234, 2'b01);
    do_read(18'h10, d, lat);
    chk("bw_rd", d, 16'hA534);
    chk("bw_model", d, exp_rd(18'h10));

    // read and write together: write wins, read dropped
    avn_read = 1'b1;
    avn_write = 1'b1;
    avn_address = 18'h00020;
    avn_writedata = 16'hBEEF;
    avn_byteenable = 2'b11;
    step;
    avn_read = 1'b0;
    avn_write = 1'b0;
    chk("rw_pins", {oe_n, we_n}, 2'b10);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (rdv) seen++;
    end
    chk("rw_no_rdv", seen, 0);
    chk("rw_mem", mem[18'h20], 16'hBEEF);
    model_write(18'h20, 16'hBEEF, 2'b11);

    // random writes into a small window
    for (int i = 0; i < 16; i++)
      do_write($urandom_range(0, 255), 16'($urandom),
               2'($urandom));

    // back-to-back random reads
    issued = 0;
    got = 0;
    for (int c = 0; c < 2000 && got < 64; c++) begin
      if (rdv) begin
        if (q_addr.size() == 0) begin
          chk("b2b_spurious", 1, 0);
        end else begin
          a = q_addr.pop_front();
          chk("b2b_data", avn_readdata, exp_rd(a));
          chk("b2b_lat", cyc - q_t.pop_front(), RD_LAT);
          chk("b2b_accept", wait_r, 0);
          got++;
        end
      end
      if (!wait_r && issued < 64) begin
        a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255)
                                        : $urandom_range(0, (1 << AW) - 1);
        avn_read = 1'b1;
        avn_address = AW'(a);
        q_addr.push_back(a);
        q_t.push_back(cyc);
        issued++;
      end else if (!wait_r) begin
        avn_read = 1'b0;
      end
      step;
    end
    avn_read = 1'b0;
    chk("b2b_count", got, 64);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (rdv) seen++;
    end
    chk("b2b_extra", seen, 0);

    // reset in the middle of a read
    avn_read = 1'b1;
    avn_address = 18'h00010;
    step;
    avn_read = 1'b0;
    chk("mr_oe", oe_n, 0);
    #2;
    probe_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_pins", {ce_n, oe_n, we_n}, 3'b111);
    chk("mr_wait", wait_r, 1);
    chk("mr_dq_hiz", sram_dq, 16'h5A5A);
    step;
    step;
    rst_n = 1'b1;
    probe_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (rdv) seen++;
    end
    chk("mr_no_rdv", seen, 0);
    do_read(18'h10, d, lat);
    chk("mr_recover", d, exp_rd(18'h10));
    chk("mr_lat", lat, RD_LAT);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
